// File: rtl/logic_serial_unit_pkg.sv
// -----------------------------------------------------------------------------
// logic_serial_unit_pkg
// Shared definitions for the slice-serial logic engine:
//   - opcode encodings (AND, OR, NOR, INV)
//   - FSM state encodings (IDLE, BUSY, DONE)
//   - default operand and slice widths
// -----------------------------------------------------------------------------
package logic_serial_unit_pkg;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_SLICE_WIDTH = 4;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOR = 2'b10;
    localparam logic [1:0] OP_INV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_BUSY = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/logic_slice.sv
// -----------------------------------------------------------------------------
// logic_slice
// Combinational bitwise logic on one SLICE_WIDTH-bit slice, built from
// per-bit gate primitives.
// Ports:
//   a_i   SLICE_WIDTH  operand A slice
//   b_i   SLICE_WIDTH  operand B slice (unused for INV)
//   op_i  2            opcode (AND, OR, NOR, INV(A))
//   y_o   SLICE_WIDTH  result slice
// -----------------------------------------------------------------------------
module logic_slice
    import logic_serial_unit_pkg::*;
#(
    parameter int SLICE_WIDTH = DEF_SLICE_WIDTH
) (
    input  logic [SLICE_WIDTH-1:0] a_i,
    input  logic [SLICE_WIDTH-1:0] b_i,
    input  logic [1:0]             op_i,
    output logic [SLICE_WIDTH-1:0] y_o
);

    logic [SLICE_WIDTH-1:0] and_s;
    logic [SLICE_WIDTH-1:0] or_s;
    logic [SLICE_WIDTH-1:0] nor_s;
    logic [SLICE_WIDTH-1:0] inv_s;

    for (genvar i = 0; i < SLICE_WIDTH; i++) begin : g_bit
        and g_and (and_s[i], a_i[i], b_i[i]);
        or  g_or  (or_s[i],  a_i[i], b_i[i]);
        nor g_nor (nor_s[i], a_i[i], b_i[i]);
        not g_inv (inv_s[i], a_i[i]);
    end

    // Select the gate output for the requested opcode
    always_comb begin
        y_o = {SLICE_WIDTH{1'b0}};
        case (op_i)
            OP_AND:  y_o = and_s;
            OP_OR:   y_o = or_s;
            OP_NOR:  y_o = nor_s;
            OP_INV:  y_o = inv_s;
            default: y_o = {SLICE_WIDTH{1'b0}};
        endcase
    end

endmodule

// File: rtl/logic_serial_unit.sv
// -----------------------------------------------------------------------------
// logic_serial_unit
// Multi-cycle slice-serial bitwise logic engine (AND, OR, NOR, INV).
// One request is accepted on IN_VALID/IN_READY, processed SLICE_WIDTH bits per
// cycle (LSB slice first) over NUM_SLICES BUSY cycles, and the result is
// offered on OUT_VALID/OUT_READY. No request/response overlap.
// Ports:
//   CLK        1           clock, rising edge
//   RST        1           synchronous active-low reset
//   IN_VALID   1           request valid
//   IN_READY   1           unit can accept a request (registered)
//   OP         2           00 AND, 01 OR, 10 NOR, 11 INV(A)
//   A, B       DATA_WIDTH  operands (B ignored for INV)
//   OUT_VALID  1           result valid (registered)
//   OUT_READY  1           consumer accepts result
//   Y          DATA_WIDTH  result (registered; partial during BUSY)
//   ZERO       1           Y == 0, qualified by OUT_VALID
//   PARITY     1           XOR-reduction of Y, only when LOGIC_SERIAL_PARITY_EN
//                          is defined
// Configuration macro: LOGIC_SERIAL_PARITY_EN
// DATA_WIDTH must be a multiple of SLICE_WIDTH.
// -----------------------------------------------------------------------------
module logic_serial_unit
    import logic_serial_unit_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int SLICE_WIDTH = DEF_SLICE_WIDTH
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [1:0]            OP,
    input  logic [DATA_WIDTH-1:0] A,
    input  logic [DATA_WIDTH-1:0] B,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] Y,
`ifdef LOGIC_SERIAL_PARITY_EN
    output logic                  PARITY,
`endif
    output logic                  ZERO
);

    localparam int NUM_SLICES = DATA_WIDTH / SLICE_WIDTH;
    localparam int CNT_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_SLICES - 1);

    state_e                  state_q, state_d;
    logic [DATA_WIDTH-1:0]   a_q, a_d;
    logic [DATA_WIDTH-1:0]   b_q, b_d;
    logic [1:0]              op_q, op_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   y_q, y_d;
    logic                    zero_q, zero_d;
    logic                    in_ready_q, in_ready_d;
    logic                    out_valid_q, out_valid_d;
`ifdef LOGIC_SERIAL_PARITY_EN
    logic                    parity_q, parity_d;
`endif

    logic [SLICE_WIDTH-1:0]  a_sl_s;
    logic [SLICE_WIDTH-1:0]  b_sl_s;
    logic [SLICE_WIDTH-1:0]  res_sl_s;

    // Pick the operand slices addressed by the slice counter
    always_comb begin
        a_sl_s = {SLICE_WIDTH{1'b0}};
        b_sl_s = {SLICE_WIDTH{1'b0}};
        for (int i = 0; i < NUM_SLICES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                a_sl_s = a_q[i*SLICE_WIDTH +: SLICE_WIDTH];
                b_sl_s = b_q[i*SLICE_WIDTH +: SLICE_WIDTH];
            end else begin
                a_sl_s = a_sl_s;
                b_sl_s = b_sl_s;
            end
        end
    end

    logic_slice #(
        .SLICE_WIDTH (SLICE_WIDTH)
    ) u_slice (
        .a_i  (a_sl_s),
        .b_i  (b_sl_s),
        .op_i (op_q),
        .y_o  (res_sl_s)
    );

    // Next-state and datapath update for the IDLE/BUSY/DONE sequencer
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        zero_d  = zero_q;
`ifdef LOGIC_SERIAL_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (IN_VALID && in_ready_q) begin
                    a_d     = A;
                    b_d     = B;
                    op_d    = OP;
                    cnt_d   = {CNT_W{1'b0}};
                    y_d     = {DATA_WIDTH{1'b0}};
                    zero_d  = 1'b0;
`ifdef LOGIC_SERIAL_PARITY_EN
                    parity_d = 1'b0;
`endif
                    state_d = ST_BUSY;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUSY: begin
                for (int i = 0; i < NUM_SLICES; i++) begin
                    if (cnt_q == CNT_W'(i)) begin
                        y_d[i*SLICE_WIDTH +: SLICE_WIDTH] = res_sl_s;
                    end else begin
                        y_d = y_d;
                    end
                end
`ifdef LOGIC_SERIAL_PARITY_EN
                parity_d = parity_q ^ (^res_sl_s);
`endif
                if (cnt_q == LAST_CNT) begin
                    // y_d already contains the final slice here
                    zero_d  = (y_d == {DATA_WIDTH{1'b0}});
                    cnt_d   = {CNT_W{1'b0}};
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + CNT_W'(1);
                    state_d = ST_BUSY;
                end
            end
            ST_DONE: begin
                if (OUT_READY) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        in_ready_d  = (state_d == ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q     <= ST_IDLE;
            a_q         <= {DATA_WIDTH{1'b0}};
            b_q         <= {DATA_WIDTH{1'b0}};
            op_q        <= 2'b00;
            cnt_q       <= {CNT_W{1'b0}};
            y_q         <= {DATA_WIDTH{1'b0}};
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef LOGIC_SERIAL_PARITY_EN
            parity_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            cnt_q       <= cnt_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
`ifdef LOGIC_SERIAL_PARITY_EN
            parity_q    <= parity_d;
`endif
        end
    end

    assign IN_READY  = in_ready_q;
    assign OUT_VALID = out_valid_q;
    assign Y         = y_q;
    assign ZERO      = zero_q;
`ifdef LOGIC_SERIAL_PARITY_EN
    assign PARITY    = parity_q;
`endif

endmodule

// File: tb/tb_logic_serial_unit.sv
// -----------------------------------------------------------------------------
// tb_logic_serial_unit
// Directed self-checking bench for logic_serial_unit with hand-computed
// expected results. PARITY is checked when LOGIC_SERIAL_PARITY_EN is defined.
// -----------------------------------------------------------------------------
module tb_logic_serial_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IN_VALID;
    logic        IN_READY;
    logic [1:0]  OP;
    logic [31:0] A;
    logic [31:0] B;
    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] Y;
    logic        ZERO;
`ifdef LOGIC_SERIAL_PARITY_EN
    logic        PARITY;
`endif

    int errors = 0;
    int checks = 0;

    logic_serial_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .IN_VALID  (IN_VALID),
        .IN_READY  (IN_READY),
        .OP        (OP),
        .A         (A),
        .B         (B),
        .OUT_VALID (OUT_VALID),
        .OUT_READY (OUT_READY),
        .Y         (Y),
`ifdef LOGIC_SERIAL_PARITY_EN
        .PARITY    (PARITY),
`endif
        .ZERO      (ZERO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Present a request for one edge (IN_READY is assumed high)
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        A = a; B = b; OP = op; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
    endtask

    // Wait for OUT_VALID with a bounded budget; returns edges waited
    task automatic wait_valid(output int n);
        n = 0;
        while (!OUT_VALID && n < 20) begin
            step();
            n++;
        end
    endtask

    // Full operation: request, latency, result, handshake
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] exp_y);
        int n;
        issue(a, b, op);
        wait_valid(n);
        check({tag, "_latency"}, 32'(n), 32'd8);
        check({tag, "_valid"}, {31'd0, OUT_VALID}, 32'd1);
        check({tag, "_y"}, Y, exp_y);
        check({tag, "_zero"}, {31'd0, ZERO}, {31'd0, (exp_y == 32'd0)});
`ifdef LOGIC_SERIAL_PARITY_EN
        check({tag, "_parity"}, {31'd0, PARITY}, {31'd0, ^exp_y});
`endif
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check({tag, "_valid_fall"}, {31'd0, OUT_VALID}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, IN_READY}, 32'd1);
    endtask

    initial begin
        int n;
        RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
        OP = 2'b00; A = 32'd0; B = 32'd0;

        // Reset for two cycles
        step();
        step();
        check("rst_in_ready", {31'd0, IN_READY}, 32'd1);
        check("rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("rst_y", Y, 32'd0);
        check("rst_zero", {31'd0, ZERO}, 32'd0);
        RST = 1'b1;
        step();

        run_op("and", 32'hF0F0_1234, 32'h0FF0_FFFF, 2'b00, 32'h00F0_1234);
        run_op("nor", 32'hFFFF_FFFF, 32'h0000_0000, 2'b10, 32'h0000_0000);
        run_op("inv", 32'h1234_5678, 32'hDEAD_BEEF, 2'b11, 32'hEDCB_A987);
        run_op("nor_mix", 32'h0F0F_0000, 32'h00FF_00F0, 2'b10, 32'hF000_FF0F);
        run_op("or7", 32'h0000_0007, 32'h0000_0000, 2'b01, 32'h0000_0007);

        // Backpressure with ignored IN_VALID pulses during BUSY and DONE
        issue(32'hA5A5_0000, 32'h0000_5A5A, 2'b01);
        check("bp_busy_ready", {31'd0, IN_READY}, 32'd0);
        A = 32'hFFFF_FFFF; B = 32'hFFFF_FFFF; OP = 2'b00; IN_VALID = 1'b1;
        step();
        IN_VALID = 1'b0;
        wait_valid(n);
        check("bp_latency", 32'(n + 1), 32'd8);
        for (int i = 0; i < 5; i++) begin
            IN_VALID = (i == 2);
            check("bp_hold_y", Y, 32'hA5A5_5A5A);
            check("bp_hold_valid", {31'd0, OUT_VALID}, 32'd1);
            check("bp_hold_in_ready", {31'd0, IN_READY}, 32'd0);
            step();
        end
        IN_VALID = 1'b0;
        check("bp_y_final", Y, 32'hA5A5_5A5A);
        OUT_READY = 1'b1;
        step();
        OUT_READY = 1'b0;
        check("bp_ready_back", {31'd0, IN_READY}, 32'd1);
        check("bp_valid_fall", {31'd0, OUT_VALID}, 32'd0);

        // Reset in the middle of BUSY
        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 2'b00);
        step(); step(); step();
        check("mid_partial_y", Y, 32'h0000_0FFF);
        RST = 1'b0;
        step();
        RST = 1'b1;
        check("mid_rst_in_ready", {31'd0, IN_READY}, 32'd1);
        check("mid_rst_out_valid", {31'd0, OUT_VALID}, 32'd0);
        check("mid_rst_y", Y, 32'd0);
        run_op("after_rst", 32'hFFFF_FFFF, 32'h8000_0001, 2'b00, 32'h8000_0001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
